// File: rtl/a_send_queue.sv
`default_nettype none
// ============================================================================
// Module      : a_send_queue
// Description : Source-domain feeder for a req/ack handshake synchroniser.
//               Buffers producer words in a DEPTH-entry FIFO and launches one
//               word at a time on adata/asend, pacing on aready. Single clock
//               domain (aclk).
// Ports       : aclk, arst_n            - clock, async active-low reset
//               wr_en, wr_data          - producer write strobe / data
//               full, level, ovf        - FIFO status (ovf sticky on drop)
//               adata, asend            - word and one-cycle launch pulse
//               aready                  - synchroniser idle / able to accept
//               tx_count                - words launched since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module a_send_queue #(
    parameter int WIDTH_D    = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  aclk,
    input  logic                  arst_n,
    input  logic                  wr_en,
    input  logic [WIDTH_D-1:0]    wr_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    output logic [WIDTH_D-1:0]    adata,
    output logic                  asend,
    input  logic                  aready,
    output logic [15:0]           tx_count
);

    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [LVL_W-1:0]      c_DEPTH   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]      c_LVL_ONE = LVL_W'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH_D-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_ovf;
    logic [WIDTH_D-1:0]     r_adata;
    logic [15:0]            r_tx_count;
    logic                   w_full;
    logic                   w_wr;
    logic                   w_pop;

    // Full is judged on start-of-cycle occupancy, so a pop in the same cycle
    // never frees a slot for that cycle's write.
    assign w_full = (r_level == c_DEPTH);
    assign w_wr   = wr_en && !w_full;
    assign w_pop  = (r_state == IDLE) && (r_level != '0) && aready;

    // Storage is deliberately not reset.
    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // State register plus the data/count registers that follow the FSM.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= IDLE;
            r_adata    <= '0;
            r_tx_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            // adata only moves on a pop, so it is frozen for the whole transfer.
            if (w_pop) begin
                r_adata <= r_mem[r_rd_ptr];
            end
            if (r_state == SEND) begin
                r_tx_count <= r_tx_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_pop)   w_state_nxt = SEND;
            SEND:                   w_state_nxt = WAIT_LOW;
            WAIT_LOW:  if (!aready) w_state_nxt = WAIT_HIGH;
            WAIT_HIGH: if (aready)  w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // asend decodes straight from the state register, so it drops the moment
    // reset asserts.
    assign asend    = (r_state == SEND);
    assign full     = w_full;
    assign level    = r_level;
    assign ovf      = r_ovf;
    assign adata    = r_adata;
    assign tx_count = r_tx_count;

endmodule
`default_nettype wire

// File: tb/tb_a_send_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_a_send_queue
// Description : Directed self-checking bench for a_send_queue (WIDTH_D=8,
//               DEPTH_LOG2=3). Drives inputs and samples outputs 1 ns after
//               each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a_send_queue;

    logic        aclk;
    logic        arst_n;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic [3:0]  level;
    logic        ovf;
    logic [7:0]  adata;
    logic        asend;
    logic        aready;
    logic [15:0] tx_count;

    int n_checks = 0;
    int n_errors = 0;

    a_send_queue #(
        .WIDTH_D    (8),
        .DEPTH_LOG2 (3)
    ) dut (
        .aclk     (aclk),
        .arst_n   (arst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .ovf      (ovf),
        .adata    (adata),
        .asend    (asend),
        .aready   (aready),
        .tx_count (tx_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Step to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        arst_n  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        aready  = rdy;
        tick();
        tick();
        arst_n = 1'b1;
        tick();
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Bench-side ack model: wait (bounded) for asend, then hold aready low
    // for 3 cycles starting the cycle after asend, then raise it again.
    // Returns found flag, cycles waited, captured word and a stability flag.
    task automatic send_one(output logic found, output int gap,
                            output logic [7:0] data, output logic stable);
        found  = 1'b0;
        gap    = 0;
        data   = 8'h00;
        stable = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (asend === 1'b1) begin
                found = 1'b1;
                gap   = c;
                break;
            end
        end
        if (found) begin
            data = adata;
            tick();
            aready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (adata !== data || asend !== 1'b0) stable = 1'b0;
            end
            aready = 1'b1;
        end
    endtask

    task automatic test_reset();
        arst_n  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        aready  = 1'b0;
        #3;
        n_checks++;
        if ({full, level, ovf, adata, asend, tx_count} !== 31'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got full=%b level=%0d ovf=%b adata=%h asend=%b tx=%0d, need all 0",
                     full, level, ovf, adata, asend, tx_count);
        end
        tick();
        arst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (level !== 4'd0 || full !== 1'b0 || asend !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got level=%0d full=%b asend=%b, need 0 0 0", level, full, asend);
        end
    endtask

    task automatic test_single();
        do_reset(1'b1);
        write_word(8'hA5);
        n_checks++;
        if (level !== 4'd1 || asend !== 1'b0) begin
            n_errors++;
            $display("FAIL single_level1: got level=%0d asend=%b, need 1 0", level, asend);
        end
        tick();
        n_checks++;
        if (asend !== 1'b1 || adata !== 8'hA5 || level !== 4'd0) begin
            n_errors++;
            $display("FAIL single_launch: got asend=%b adata=%h level=%0d, need 1 a5 0", asend, adata, level);
        end
        tick();
        n_checks++;
        if (asend !== 1'b0 || tx_count !== 16'd1) begin
            n_errors++;
            $display("FAIL single_after: got asend=%b tx=%0d, need 0 1", asend, tx_count);
        end
        aready = 1'b0;
        tick();
        tick();
        aready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (asend !== 1'b0 || adata !== 8'hA5) begin
                n_errors++;
                $display("FAIL single_no_resend: cycle %0d got asend=%b adata=%h, need 0 a5", k, asend, adata);
            end
        end
    endtask

    task automatic test_overflow();
        logic       f;
        logic       st;
        int         g;
        logic [7:0] d;
        do_reset(1'b0);
        for (int i = 1; i <= 10; i++) write_word(8'(i));
        n_checks++;
        if (full !== 1'b1 || level !== 4'd8 || ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_full: got full=%b level=%0d ovf=%b, need 1 8 1", full, level, ovf);
        end
        aready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send_one(f, g, d, st);
            n_checks++;
            if (f !== 1'b1 || d !== 8'(i)) begin
                n_errors++;
                $display("FAIL ovf_order: word %0d got found=%b data=%h, need 1 %h", i, f, d, 8'(i));
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (asend !== 1'b0) begin
                n_errors++;
                $display("FAIL ovf_extra_send: cycle %0d got asend=%b, need 0", k, asend);
            end
        end
        n_checks++;
        if (level !== 4'd0 || tx_count !== 16'd8 || ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_drain: got level=%0d tx=%0d ovf=%b, need 0 8 1", level, tx_count, ovf);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    for (int w = 0; w < 200 && full === 1'b1; w++) tick();
                    write_word(8'h40 + 8'(i));
                end
            end
            begin
                logic       f;
                logic       st;
                int         g;
                logic [7:0] d;
                for (int i = 0; i < 20; i++) begin
                    send_one(f, g, d, st);
                    n_checks++;
                    if (f !== 1'b1 || d !== 8'h40 + 8'(i)) begin
                        n_errors++;
                        $display("FAIL stream_order: word %0d got found=%b data=%h, need 1 %h",
                                 i, f, d, 8'h40 + 8'(i));
                    end
                    n_checks++;
                    if (st !== 1'b1) begin
                        n_errors++;
                        $display("FAIL stream_stable: word %0d adata/asend changed while aready=0", i);
                    end
                    if (i > 0) begin
                        n_checks++;
                        if (g < 2) begin
                            n_errors++;
                            $display("FAIL stream_gap: word %0d got gap=%0d after aready rise, need >=2", i, g);
                        end
                    end
                end
            end
        join
        tick();
        n_checks++;
        if (tx_count !== 16'd20 || level !== 4'd0) begin
            n_errors++;
            $display("FAIL stream_count: got tx=%0d level=%0d, need 20 0", tx_count, level);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(1'b0);
        write_word(8'h11);
        write_word(8'h12);
        write_word(8'h13);
        aready  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h14;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (level !== 4'd3 || asend !== 1'b1 || adata !== 8'h11) begin
            n_errors++;
            $display("FAIL simul_level: got level=%0d asend=%b adata=%h, need 3 1 11", level, asend, adata);
        end
        tick();
        aready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) write_word(8'h20 + 8'(i));
        n_checks++;
        if (level !== 4'd8 || full !== 1'b1 || ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_fill: got level=%0d full=%b ovf=%b, need 8 1 0", level, full, ovf);
        end
        aready = 1'b1;
        tick();
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (level !== 4'd7 || ovf !== 1'b1 || full !== 1'b0 || asend !== 1'b1 || adata !== 8'h12) begin
            n_errors++;
            $display("FAIL simul_drop: got level=%0d ovf=%b full=%b asend=%b adata=%h, need 7 1 0 1 12",
                     level, ovf, full, asend, adata);
        end
    endtask

    task automatic test_reset_midflight();
        logic       f;
        logic       st;
        int         g;
        logic [7:0] d;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) write_word(8'h50 + 8'(i));
        n_checks++;
        if (level !== 4'd4 || tx_count !== 16'd1 || asend !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_pre: got level=%0d tx=%0d asend=%b, need 4 1 0", level, tx_count, asend);
        end
        #2;
        arst_n = 1'b0;
        #1;
        n_checks++;
        if (asend !== 1'b0 || level !== 4'd0 || tx_count !== 16'd0 || adata !== 8'h00 || ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async: got asend=%b level=%0d tx=%0d adata=%h ovf=%b, need all 0",
                     asend, level, tx_count, adata, ovf);
        end
        tick();
        arst_n = 1'b1;
        tick();
        write_word(8'h3C);
        send_one(f, g, d, st);
        n_checks++;
        if (f !== 1'b1 || d !== 8'h3C || g !== 1) begin
            n_errors++;
            $display("FAIL midrst_resend: got found=%b data=%h gap=%0d, need 1 3c 1", f, d, g);
        end
        tick();
        n_checks++;
        if (tx_count !== 16'd1 || level !== 4'd0) begin
            n_errors++;
            $display("FAIL midrst_count: got tx=%0d level=%0d, need 1 0", tx_count, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_stream();
        test_simultaneous();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
